shift_add_multiplier: RTL and testbench

SHIFT_ADD_MULTIPLIER -- requirements
Module: shift_add_multiplier

---
 rtl/mul_pkg.sv | 16 +
 rtl/ripple_carry_adder.sv | 26 ++
 rtl/shift_add_multiplier_dp.sv | 72 +++++++
 rtl/shift_add_multiplier.sv | 101 ++++++++++
 tb/tb_shift_add_multiplier.sv | 225 ++++++++++++++++++++++
 5 files changed

// File: rtl/mul_pkg.sv
// Shared types and constants for the shift-add multiplier.
package mul_pkg;

  localparam int unsigned OP_W   = 4;
  localparam int unsigned PROD_W = 8;
  localparam int unsigned ITER_W = 2;

  localparam logic [ITER_W-1:0] ITER_LAST = 2'd3;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CALC = 2'd1,
    DONE = 2'd2
  } mul_state_e;

endpackage

// File: rtl/ripple_carry_adder.sv
// Plain ripple-carry adder built from a chain of full-adder cells.
module ripple_carry_adder #(
  parameter int unsigned W = 4
) (
  input  logic [W-1:0] a,
  input  logic [W-1:0] b,
  input  logic         cin,
  output logic [W-1:0] sum,
  output logic         cout
);

  logic [W:0] carry;

  always_comb begin
    carry    = '0;
    sum      = '0;
    carry[0] = cin;
    for (int i = 0; i < W; i++) begin
      sum[i]     = a[i] ^ b[i] ^ carry[i];
      carry[i+1] = (a[i] & b[i]) | (a[i] & carry[i]) | (b[i] & carry[i]);
    end
  end

  assign cout = carry[W];

endmodule

// File: rtl/shift_add_multiplier_dp.sv
// Operand/accumulator registers and the single add stage of the shift-add multiplier.
module shift_add_multiplier_dp
  import mul_pkg::*;
(
  input  logic              clk,
  input  logic              rst_n,
  input  logic              load,
  input  logic              step,
  input  logic [OP_W-1:0]   a,
  input  logic [OP_W-1:0]   b,
  output logic              iter_last,
  output logic [PROD_W-1:0] acc
);

  logic [OP_W-1:0]   mcand_q, mcand_d;
  logic [OP_W-1:0]   acc_hi_q, acc_hi_d;
  logic [OP_W-1:0]   acc_lo_q, acc_lo_d;
  logic [ITER_W-1:0] iter_q, iter_d;

  logic [OP_W-1:0] add_sum;
  logic            add_cout;
  logic [OP_W:0]   partial;

  ripple_carry_adder #(
    .W (OP_W)
  ) u_adder (
    .a    (acc_hi_q),
    .b    (mcand_q),
    .cin  (1'b0),
    .sum  (add_sum),
    .cout (add_cout)
  );

  // Add the multiplicand only when the current multiplier bit is set.
  assign partial = acc_lo_q[0] ? {add_cout, add_sum} : {1'b0, acc_hi_q};

  always_comb begin
    mcand_d  = mcand_q;
    acc_hi_d = acc_hi_q;
    acc_lo_d = acc_lo_q;
    iter_d   = iter_q;
    if (load) begin
      mcand_d  = a;
      acc_hi_d = '0;
      acc_lo_d = b;
      iter_d   = '0;
    end else if (step) begin
      // Shift {carry, sum, acc_lo} right by one as a single 9-bit word.
      acc_hi_d = partial[OP_W:1];
      acc_lo_d = {partial[0], acc_lo_q[OP_W-1:1]};
      iter_d   = iter_q + ITER_W'(1);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mcand_q  <= '0;
      acc_hi_q <= '0;
      acc_lo_q <= '0;
      iter_q   <= '0;
    end else begin
      mcand_q  <= mcand_d;
      acc_hi_q <= acc_hi_d;
      acc_lo_q <= acc_lo_d;
      iter_q   <= iter_d;
    end
  end

  assign iter_last = (iter_q == ITER_LAST);
  assign acc       = {acc_hi_q, acc_lo_q};

endmodule

// File: rtl/shift_add_multiplier.sv
// 4x4 unsigned shift-add multiplier with valid/ready handshakes on both sides.
// Define MUL_OP_COUNT_EN to add the op_count transfer counter port.
module shift_add_multiplier
  import mul_pkg::*;
#(
  parameter int unsigned CNT_W = 8
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [OP_W-1:0]   a,
  input  logic [OP_W-1:0]   b,
  output logic              out_valid,
  input  logic              out_ready,
`ifdef MUL_OP_COUNT_EN
  output logic [PROD_W-1:0] product,
  output logic [CNT_W-1:0]  op_count
`else
  output logic [PROD_W-1:0] product
`endif
);

  if (CNT_W < 1 || CNT_W > 16) begin : g_bad_cnt_w
    $error("CNT_W must be in 1..16");
  end

  mul_state_e state_q, state_d;

  logic              load;
  logic              step;
  logic              iter_last;
  logic [PROD_W-1:0] acc;

  shift_add_multiplier_dp u_dp (
    .clk       (clk),
    .rst_n     (rst_n),
    .load      (load),
    .step      (step),
    .a         (a),
    .b         (b),
    .iter_last (iter_last),
    .acc       (acc)
  );

  always_comb begin
    state_d   = state_q;
    in_ready  = 1'b0;
    out_valid = 1'b0;
    load      = 1'b0;
    step      = 1'b0;
    unique case (state_q)
      IDLE: begin
        in_ready = 1'b1;
        if (in_valid) begin
          load    = 1'b1;
          state_d = CALC;
        end
      end
      CALC: begin
        step = 1'b1;
        if (iter_last) begin
          state_d = DONE;
        end
      end
      DONE: begin
        out_valid = 1'b1;
        if (out_ready) begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // The accumulator holds partial sums mid-calculation; only expose it in DONE.
  assign product = out_valid ? acc : '0;

`ifdef MUL_OP_COUNT_EN
  logic [CNT_W-1:0] op_count_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      op_count_q <= '0;
    end else if (out_valid && out_ready) begin
      op_count_q <= op_count_q + CNT_W'(1);
    end
  end

  assign op_count = op_count_q;
`endif

endmodule

// File: tb/tb_shift_add_multiplier.sv
// Scoreboard bench for shift_add_multiplier: random and directed operands against a*b.
module tb_shift_add_multiplier;

  localparam int unsigned CNT_W = 8;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       in_valid = 1'b0;
  logic       out_ready = 1'b0;
  logic [3:0] a = '0;
  logic [3:0] b = '0;
  logic       in_ready;
  logic       out_valid;
  logic [7:0] product;
`ifdef MUL_OP_COUNT_EN
  logic [CNT_W-1:0] op_count;
`endif

  shift_add_multiplier #(
    .CNT_W (CNT_W)
  ) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .a         (a),
    .b         (b),
    .out_valid (out_valid),
    .out_ready (out_ready),
`ifdef MUL_OP_COUNT_EN
    .product   (product),
    .op_count  (op_count)
`else
    .product   (product)
`endif
  );

  always #5 clk = ~clk;

  int          vectors = 0;
  int          miscompares = 0;
  int unsigned exp_q[$];
  int          cyc = 0;
  int          acc_cyc = 0;
  int          n_xfer = 0;
  bit          wait_lat = 0;
  bit          busy = 0;
  bit          prev_ov = 0;
  bit          prev_or = 0;
  logic [7:0]  prev_prod = '0;
  bit          rand_ready = 0;

  task automatic check(input string name, input int act, input int exp);
    vectors++;
    if (act != exp) begin
      miscompares++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Monitor: records accepted operands, checks every presented product.
  always @(negedge clk) begin
    if (!rst_n) begin
      exp_q.delete();
      wait_lat = 0;
      busy     = 0;
      prev_ov  = 0;
      prev_or  = 0;
      n_xfer   = 0;
      cyc      = 0;
    end else begin
      cyc++;
      if (!out_valid) check("product_zero_when_invalid", int'(product), 0);
      if (busy) check("in_ready_low_while_busy", int'(in_ready), 0);
      if (out_valid && prev_ov && !prev_or) check("product_hold", int'(product), int'(prev_prod));
      if (out_valid && wait_lat) begin
        check("latency", cyc - acc_cyc, 5);
        wait_lat = 0;
      end
      if (out_valid && out_ready) begin
        if (exp_q.size() == 0) check("unexpected_output", exp_q.size(), 1);
        else check("product", int'(product), int'(exp_q.pop_front()));
        busy = 0;
        n_xfer++;
      end
      if (in_valid && in_ready) begin
        exp_q.push_back(int'(a) * int'(b));
        acc_cyc  = cyc;
        wait_lat = 1;
        busy     = 1;
      end
      prev_ov   = out_valid;
      prev_or   = out_ready;
      prev_prod = product;
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
    if (rand_ready) out_ready = ($urandom_range(0, 3) != 0);
  endtask

  task automatic send(input logic [3:0] av, input logic [3:0] bv);
    bit ok;
    bit acc;
    ok       = 0;
    a        = av;
    b        = bv;
    in_valid = 1'b1;
    for (int i = 0; i < 60; i++) begin
      acc = in_ready;
      tick();
      if (acc) begin
        ok = 1;
        break;
      end
    end
    in_valid = 1'b0;
    a        = 4'($urandom);
    b        = 4'($urandom);
    check("accept_timeout", int'(ok), 1);
  endtask

  task automatic wait_idle();
    bit done;
    done = 0;
    for (int i = 0; i < 80; i++) begin
      if (exp_q.size() == 0 && in_ready) begin
        done = 1;
        break;
      end
      tick();
    end
    check("drain_timeout", int'(done), 1);
  endtask

  task automatic check_reset_outputs();
    check("rst_in_ready", int'(in_ready), 1);
    check("rst_out_valid", int'(out_valid), 0);
    check("rst_product", int'(product), 0);
`ifdef MUL_OP_COUNT_EN
    check("rst_op_count", int'(op_count), 0);
`endif
  endtask

  initial begin
    bit seen;
    #1;
    check_reset_outputs();
    @(posedge clk);
    #1;
    rst_n = 1'b1;

    // Basic latency, extremes and zero operands with the consumer always ready.
    rand_ready = 0;
    out_ready  = 1'b1;
    send(4'd3, 4'd5);
    wait_idle();
    send(4'd15, 4'd15);
    send(4'd0, 4'd9);
    send(4'd9, 4'd0);
    wait_idle();

    // Backpressure: seven stalled cycles with the input side toggling.
    out_ready = 1'b0;
    send(4'd11, 4'd13);
    seen = 0;
    for (int i = 0; i < 20; i++) begin
      if (out_valid) begin
        seen = 1;
        break;
      end
      tick();
    end
    check("out_valid_timeout", int'(seen), 1);
    for (int i = 0; i < 7; i++) begin
      in_valid = 1'($urandom);
      a        = 4'($urandom);
      b        = 4'($urandom);
      tick();
    end
    in_valid  = 1'b0;
    out_ready = 1'b1;
    wait_idle();

    // Reset while CALC is on its third iteration.
    send(4'd6, 4'd7);
    tick();
    tick();
    rst_n = 1'b0;
    #1;
    check_reset_outputs();
    tick();
    rst_n = 1'b1;
    send(4'd2, 4'd7);
    wait_idle();

    // Random operands with random consumer stalls.
    rand_ready = 1;
    for (int i = 0; i < 40; i++) send(4'($urandom), 4'($urandom));
    wait_idle();

    // Every operand pair, random stalls.
    for (int i = 0; i < 16; i++) begin
      for (int j = 0; j < 16; j++) send(4'(i), 4'(j));
    end
    wait_idle();

`ifdef MUL_OP_COUNT_EN
    check("op_count", int'(op_count), n_xfer % (1 << CNT_W));
`endif
    check("transfers", n_xfer, 1 + 40 + 256);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish, got timeout, expected completion");
    $fatal(1, "watchdog");
  end

endmodule
